// File: rtl/axis_video_stats.sv
// Per-frame statistics sink for an RGB565 AXI4-Stream video path.
// Measures width, height, pixel count and luma sum per frame, flags framing errors, drives an LED brightness byte.
module axis_video_stats #(
    parameter int CNT_W      = 12,
    parameter int LUMA_SHIFT = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      s_axis_video_tdata,
    input  logic             s_axis_video_tvalid,
    output logic             s_axis_video_tready,
    input  logic             s_axis_video_tuser,
    input  logic             s_axis_video_tlast,
    output logic             stat_valid,
    output logic [CNT_W-1:0] frame_width,
    output logic [CNT_W-1:0] frame_height,
    output logic [23:0]      pixel_count,
    output logic [31:0]      luma_sum,
    output logic             frame_err,
    output logic [15:0]      frame_count,
    output logic [7:0]       LED
);

    typedef enum logic {WAIT_SOF, IN_FRAME} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic             rdy_q;
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d, wid_q, wid_d;
    logic [23:0]      pix_q, pix_d;
    logic [31:0]      acc_q, acc_d;
    logic             err_q, err_d;
    logic [7:0]       y_q;
    logic             yv_q;

    logic             beat, sof, close, take;
    logic [7:0]       r8, g8, b8, y_c;
    logic [10:0]      ysum;
    logic [CNT_W-1:0] col_b, row_b, wid_b, col_inc;
    logic [23:0]      pix_b;
    logic             err_b;
    logic [31:0]      luma_close, luma_shr;
    logic [7:0]       led_c;

    assign s_axis_video_tready = rdy_q;

    assign beat  = s_axis_video_tvalid & rdy_q;
    assign sof   = beat & s_axis_video_tuser;
    assign close = sof & (state_q == IN_FRAME);
    assign take  = beat & (s_axis_video_tuser | (state_q == IN_FRAME));

    assign r8   = {s_axis_video_tdata[15:11], s_axis_video_tdata[15:13]};
    assign g8   = {s_axis_video_tdata[10:5],  s_axis_video_tdata[10:9]};
    assign b8   = {s_axis_video_tdata[4:0],   s_axis_video_tdata[4:2]};
    assign ysum = 11'(r8) * 11'd2 + 11'(g8) * 11'd5 + 11'(b8);
    assign y_c  = ysum[10:3];

    // A start-of-frame beat is counted against freshly cleared frame state.
    assign col_b   = sof ? '0 : col_q;
    assign row_b   = sof ? '0 : row_q;
    assign wid_b   = sof ? '0 : wid_q;
    assign pix_b   = sof ? '0 : pix_q;
    assign err_b   = sof ? 1'b0 : err_q;
    assign col_inc = (col_b == CNT_MAX) ? CNT_MAX : col_b + CNT_ONE;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        wid_d = wid_q;
        pix_d = pix_q;
        err_d = err_q;
        if (take) begin
            pix_d = pix_b + 24'd1;
            row_d = row_b;
            wid_d = wid_b;
            col_d = col_inc;
            err_d = err_b | (col_b == CNT_MAX) | ((col_inc == CNT_MAX) & ~s_axis_video_tlast);
            if (s_axis_video_tlast) begin
                col_d = '0;
                row_d = (row_b == CNT_MAX) ? CNT_MAX : row_b + CNT_ONE;
                if (row_b == '0)
                    wid_d = col_inc;
                else if (col_inc != wid_b)
                    err_d = 1'b1;
            end
        end
    end

    // The last pixel's luma may still sit in the pipeline register at close time.
    always_comb begin
        acc_d = acc_q;
        if (sof)
            acc_d = '0;
        else if (yv_q)
            acc_d = acc_q + {24'd0, y_q};
    end

    assign luma_close = acc_q + (yv_q ? {24'd0, y_q} : 32'd0);
    assign luma_shr   = luma_close >> LUMA_SHIFT;
    assign led_c      = (|luma_shr[31:8]) ? 8'hFF : luma_shr[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_SOF;
            rdy_q        <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            wid_q        <= '0;
            pix_q        <= '0;
            acc_q        <= '0;
            err_q        <= 1'b0;
            y_q          <= '0;
            yv_q         <= 1'b0;
            stat_valid   <= 1'b0;
            frame_width  <= '0;
            frame_height <= '0;
            pixel_count  <= '0;
            luma_sum     <= '0;
            frame_err    <= 1'b0;
            frame_count  <= '0;
            LED          <= '0;
        end else begin
            rdy_q      <= 1'b1;
            col_q      <= col_d;
            row_q      <= row_d;
            wid_q      <= wid_d;
            pix_q      <= pix_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            y_q        <= y_c;
            yv_q       <= take;
            stat_valid <= close;
            if (sof)
                state_q <= IN_FRAME;
            if (close) begin
                frame_width  <= wid_q;
                frame_height <= row_q;
                pixel_count  <= pix_q;
                luma_sum     <= luma_close;
                frame_err    <= err_q | (col_q != '0);
                frame_count  <= frame_count + 16'd1;
                LED          <= led_c;
            end
        end
    end

endmodule
